// File: rtl/ldst_pkg.sv
// Shared types and widths for the load/store unit and its stack-pointer register.
package ldst_pkg;

  localparam int DATA_W = 8;
  localparam int ADDR_W = 8;

  typedef enum logic [2:0] {
    OP_NOP   = 3'd0,
    OP_LOAD  = 3'd1,
    OP_STORE = 3'd2,
    OP_PUSH  = 3'd3,
    OP_POP   = 3'd4
  } op_e;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ACCESS,
    ST_DONE
  } state_e;

endpackage

// File: rtl/ldst_unit_sp.sv
// Hardware stack pointer (next free slot); updates on the edge that ends a PUSH/POP access.
// LDST_STACK_CHECK_EN adds full/empty detection; without it the pointer wraps modulo 256.
module ldst_sp
  import ldst_pkg::*;
#(
  parameter logic [ADDR_W-1:0] SP_RESET = 8'hFF
`ifdef LDST_STACK_CHECK_EN
  , parameter logic [ADDR_W-1:0] STACK_LIMIT = 8'hC0
`endif
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              push,
  input  logic              pop,
  output logic [ADDR_W-1:0] sp,
  output logic              full,
  output logic              empty
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sp <= SP_RESET;
    end else if (push) begin
      sp <= sp - 8'd1;
    end else if (pop) begin
      sp <= sp + 8'd1;
    end
  end

`ifdef LDST_STACK_CHECK_EN
  assign full  = (sp == STACK_LIMIT - 8'd1);
  assign empty = (sp == SP_RESET);
`else
  assign full  = 1'b0;
  assign empty = 1'b0;
`endif

endmodule

// File: rtl/ldst_unit.sv
// Load/store/stack stage: one request at a time, latency 1 (NOP/error) or 2 (memory op); response held until resp_ready.
// Memory outputs decode from registered state only. LDST_STACK_CHECK_EN enables stack overflow/underflow errors.
module ldst_unit
  import ldst_pkg::*;
#(
  parameter logic [ADDR_W-1:0] SP_RESET = 8'hFF
`ifdef LDST_STACK_CHECK_EN
  , parameter logic [ADDR_W-1:0] STACK_LIMIT = 8'hC0
`endif
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [2:0]        req_op,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              resp_valid,
  input  logic              resp_ready,
  output logic [DATA_W-1:0] resp_rdata,
  output logic              resp_err,
  output logic [ADDR_W-1:0] sp_out,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_wr_en,
  output logic [DATA_W-1:0] mem_dat_in,
  input  logic [DATA_W-1:0] mem_dat_out
);

  state_e            state_q, state_d;
  logic [2:0]        op_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q;
  logic [DATA_W-1:0] rdata_q;
  logic              err_q;
  logic              accept, req_err;
  logic              sp_push, sp_pop, sp_full, sp_empty;
  logic [ADDR_W-1:0] sp;

  ldst_sp #(
    .SP_RESET   (SP_RESET)
`ifdef LDST_STACK_CHECK_EN
    , .STACK_LIMIT(STACK_LIMIT)
`endif
  ) u_sp (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (sp_push),
    .pop   (sp_pop),
    .sp    (sp),
    .full  (sp_full),
    .empty (sp_empty)
  );

  always_comb begin
    state_d    = state_q;
    req_ready  = 1'b0;
    resp_valid = 1'b0;
    mem_wr_en  = 1'b0;
    mem_addr   = '0;
    mem_dat_in = '0;
    sp_push    = 1'b0;
    sp_pop     = 1'b0;
    accept     = 1'b0;
    req_err    = (req_op > OP_POP)
              || (req_op == OP_PUSH && sp_full)
              || (req_op == OP_POP  && sp_empty);
    case (state_q)
      ST_IDLE: begin
        req_ready = 1'b1;
        if (req_valid) begin
          accept  = 1'b1;
          state_d = (req_err || req_op == OP_NOP) ? ST_DONE : ST_ACCESS;
        end
      end
      ST_ACCESS: begin
        mem_dat_in = wdata_q;
        case (op_q)
          OP_LOAD:  mem_addr = addr_q;
          OP_STORE: begin
            mem_addr  = addr_q;
            mem_wr_en = 1'b1;
          end
          OP_PUSH: begin
            mem_addr  = sp;
            mem_wr_en = 1'b1;
            sp_push   = 1'b1;
          end
          OP_POP: begin
            mem_addr = sp + 8'd1;
            sp_pop   = 1'b1;
          end
          default: ;
        endcase
        state_d = ST_DONE;
      end
      ST_DONE: begin
        resp_valid = 1'b1;
        if (resp_ready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // rdata is cleared on accept so NOP, STORE, PUSH and rejected ops return zero.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_q    <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else if (accept) begin
      op_q    <= req_op;
      addr_q  <= req_addr;
      wdata_q <= req_wdata;
      rdata_q <= '0;
      err_q   <= req_err;
    end else if (state_q == ST_ACCESS && (op_q == OP_LOAD || op_q == OP_POP)) begin
      rdata_q <= mem_dat_out;
    end
  end

  assign resp_rdata = rdata_q;
  assign resp_err   = err_q;
  assign sp_out     = sp;

endmodule

// File: tb/tb_ldst_unit.sv
// Scoreboard bench for ldst_unit: driver queues expected responses/writes, monitors compare.
module tb_ldst_unit;
  import ldst_pkg::*;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       req_valid, req_ready, resp_valid, resp_ready, resp_err, mem_wr_en;
  logic [2:0] req_op;
  logic [7:0] req_addr, req_wdata, resp_rdata, sp_out, mem_addr, mem_dat_in, mem_dat_out;
  logic [7:0] mem [256];

  int checks = 0;
  int failures = 0;
  int cyc = 0;

  typedef struct {
    logic [7:0] rdata;
    logic       err;
    int         lat;
    int         hold;
    int         acc;
  } exp_t;
  typedef struct {
    logic [7:0] a;
    logic [7:0] d;
  } wr_t;
  exp_t exp_q[$];
  wr_t  wr_q[$];

  ldst_unit dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
    .req_op(req_op), .req_addr(req_addr), .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_rdata(resp_rdata),
    .resp_err(resp_err), .sp_out(sp_out), .mem_addr(mem_addr), .mem_wr_en(mem_wr_en),
    .mem_dat_in(mem_dat_in), .mem_dat_out(mem_dat_out)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial for (int i = 0; i < 256; i++) mem[i] <= 8'h00;
  always @(posedge clk) if (mem_wr_en) mem[mem_addr] <= mem_dat_in;
  assign mem_dat_out = mem[mem_addr];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
    end
  endtask

  // Response monitor: compares latency and payload, optionally stalls, then accepts.
  initial begin
    exp_t e;
    resp_ready = 1'b0;
    forever begin
      @(negedge clk);
      if (rst_n && resp_valid) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_resp", 1, 0);
        end else begin
          e = exp_q.pop_front();
          chk("resp_latency", cyc - e.acc + 1, e.lat);
          chk("resp_rdata", resp_rdata, e.rdata);
          chk("resp_err", resp_err, e.err);
          for (int h = 0; h < e.hold; h++) begin
            @(negedge clk);
            chk("hold_valid", resp_valid, 1);
            chk("hold_rdata", resp_rdata, e.rdata);
            chk("hold_err", resp_err, e.err);
            chk("hold_req_ready", req_ready, 0);
            chk("hold_mem_addr", mem_addr, 0);
          end
        end
        resp_ready = 1'b1;
        @(negedge clk);
        resp_ready = 1'b0;
      end
    end
  end

  // Write monitor: every write-enable cycle must match the next expected write.
  always @(negedge clk) begin
    if (mem_wr_en) begin
      if (wr_q.size() == 0) begin
        chk("unexpected_write", 1, 0);
      end else begin
        chk("write_addr", mem_addr, wr_q[0].a);
        chk("write_data", mem_dat_in, wr_q[0].d);
        void'(wr_q.pop_front());
      end
    end
  end

  task automatic issue(input logic [2:0] op, input logic [7:0] addr, input logic [7:0] wdata,
                       input logic [7:0] e_rdata, input logic e_err, input int e_lat,
                       input int hold, input bit e_wr, input logic [7:0] wa);
    int n = 0;
    exp_t e;
    wr_t  w;
    @(negedge clk);
    while (!req_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk("req_ready_wait_timeout", n >= 200, 0);
    req_valid = 1'b1;
    req_op    = op;
    req_addr  = addr;
    req_wdata = wdata;
    @(posedge clk);
    #1;
    e.rdata = e_rdata; e.err = e_err; e.lat = e_lat; e.hold = hold; e.acc = cyc;
    exp_q.push_back(e);
    if (e_wr) begin
      w.a = wa; w.d = wdata;
      wr_q.push_back(w);
    end
    @(negedge clk);
    req_valid = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    while ((exp_q.size() != 0 || wr_q.size() != 0 || !req_ready) && n < 300) begin
      @(negedge clk);
      n++;
    end
    chk("drain_timeout", n >= 300, 0);
  endtask

  task automatic do_reset();
    drain();
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  initial begin
    rst_n = 1'b0; req_valid = 1'b0; req_op = 3'd0; req_addr = 8'h00; req_wdata = 8'h00;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    chk("rst_req_ready", req_ready, 1);
    chk("rst_resp_valid", resp_valid, 0);
    chk("rst_sp", sp_out, 8'hFF);
    chk("rst_wr_en", mem_wr_en, 0);
    chk("rst_mem_addr", mem_addr, 0);
    chk("rst_mem_din", mem_dat_in, 0);
    chk("rst_rdata", resp_rdata, 0);
    chk("rst_err", resp_err, 0);

    // STORE then LOAD
    issue(OP_STORE, 8'h10, 8'hA5, 8'h00, 0, 2, 0, 1, 8'h10);
    issue(OP_LOAD,  8'h10, 8'h00, 8'hA5, 0, 2, 0, 0, 8'h00);
    issue(OP_NOP,   8'h10, 8'h00, 8'h00, 0, 1, 0, 0, 8'h00);
    drain();

    // PUSH/PUSH/POP/POP
    issue(OP_PUSH, 8'h00, 8'h11, 8'h00, 0, 2, 0, 1, 8'hFF);
    issue(OP_PUSH, 8'h00, 8'h22, 8'h00, 0, 2, 0, 1, 8'hFE);
    drain();
    chk("sp_after_2push", sp_out, 8'hFD);
    issue(OP_POP, 8'h00, 8'h00, 8'h22, 0, 2, 0, 0, 8'h00);
    issue(OP_POP, 8'h00, 8'h00, 8'h11, 0, 2, 0, 0, 8'h00);
    drain();
    chk("sp_after_2pop", sp_out, 8'hFF);

    // Illegal ops, one with a 3-cycle consumer stall
    issue(3'd7, 8'h44, 8'h99, 8'h00, 1, 1, 3, 0, 8'h00);
    issue(3'd5, 8'h10, 8'h99, 8'h00, 1, 1, 0, 0, 8'h00);
    drain();
    chk("sp_after_illegal", sp_out, 8'hFF);

    // Fill the 64-entry stack, then one more PUSH and a POP
    for (int i = 0; i < 64; i++)
      issue(OP_PUSH, 8'h00, 8'(i), 8'h00, 0, 2, 0, 1, 8'(8'hFF - i));
    drain();
    chk("sp_after_64push", sp_out, 8'hBF);
`ifdef LDST_STACK_CHECK_EN
    issue(OP_PUSH, 8'h00, 8'h40, 8'h00, 1, 1, 0, 0, 8'h00);
    drain();
    chk("sp_after_overflow", sp_out, 8'hBF);
    issue(OP_POP, 8'h00, 8'h00, 8'h3F, 0, 2, 0, 0, 8'h00);
    drain();
    chk("sp_after_pop_full", sp_out, 8'hC0);
`else
    issue(OP_PUSH, 8'h00, 8'h40, 8'h00, 0, 2, 0, 1, 8'hBF);
    drain();
    chk("sp_after_65push", sp_out, 8'hBE);
    issue(OP_POP, 8'h00, 8'h00, 8'h40, 0, 2, 0, 0, 8'h00);
    drain();
    chk("sp_after_pop_65", sp_out, 8'hBF);
`endif
    do_reset();

    // POP from the reset (empty) position
`ifdef LDST_STACK_CHECK_EN
    issue(OP_POP, 8'h00, 8'h00, 8'h00, 1, 1, 0, 0, 8'h00);
    drain();
    chk("sp_after_underflow", sp_out, 8'hFF);
`else
    issue(OP_POP, 8'h00, 8'h00, 8'h00, 0, 2, 0, 0, 8'h00);
    drain();
    chk("sp_after_wrap_pop", sp_out, 8'h00);
`endif
    do_reset();

    // Reset asserted during the ACCESS cycle of a STORE
    issue(OP_PUSH, 8'h00, 8'h66, 8'h00, 0, 2, 0, 1, 8'hFF);
    drain();
    chk("sp_before_rst", sp_out, 8'hFE);
    @(negedge clk);
    req_valid = 1'b1; req_op = OP_STORE; req_addr = 8'h33; req_wdata = 8'h5A;
    @(posedge clk);
    #2;
    req_valid = 1'b0;
    chk("access_wr_en", mem_wr_en, 1);
    chk("access_addr", mem_addr, 8'h33);
    rst_n = 1'b0;
    #1;
    chk("rst_mid_wr_en", mem_wr_en, 0);
    chk("rst_mid_addr", mem_addr, 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("post_rst_sp", sp_out, 8'hFF);
    chk("post_rst_resp_valid", resp_valid, 0);
    chk("post_rst_req_ready", req_ready, 1);

    issue(OP_LOAD, 8'h10, 8'h00, 8'hA5, 0, 2, 0, 0, 8'h00);
    drain();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout actual=%0d expected=finish", cyc);
    $fatal(1, "timeout");
  end

endmodule
